round_timer: RTL

ROUND_TIMER -- requirements
Module: round_timer

---
 rtl/round_timer_pkg.sv | 65 ++++++
 rtl/round_timer_seg7.sv | 22 ++
 rtl/round_timer.sv | 147 ++++++++++++++
 3 files changed

// File: rtl/round_timer_pkg.sv
// ---------------------------------------------------------------------------
// round_timer_pkg
// Shared types and constants for the round timer:
//   state_e      : FSM states (IDLE, RUN, PAUSE, DONE)
//   digits_t     : the M:SS display value as three BCD digits
//   SEG_DIGITS   : active-low 7-segment patterns (gfedcba) for 0..9
//   SEG_BLANK    : all segments off
//   digits_step  : advance an M:SS value by one second up or down
// ---------------------------------------------------------------------------
package round_timer_pkg;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    PAUSE,
    DONE
  } state_e;

  typedef struct packed {
    logic [3:0] min_ones;
    logic [3:0] sec_tens;
    logic [3:0] sec_ones;
  } digits_t;

  localparam logic [6:0] SEG_BLANK = 7'b1111111;

  localparam logic [6:0] SEG_DIGITS [10] = '{
    7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
    7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000
  };

  // One-second step with BCD carry/borrow. Down steps never start from 0:00
  // because the FSM stops there, so the minute borrow cannot underflow.
  function automatic digits_t digits_step(input digits_t d, input logic down);
    digits_t r;
    r = d;
    if (!down) begin
      if (d.sec_ones == 4'd9) begin
        r.sec_ones = 4'd0;
        if (d.sec_tens == 4'd5) begin
          r.sec_tens = 4'd0;
          r.min_ones = (d.min_ones == 4'd9) ? 4'd0 : d.min_ones + 4'd1;
        end else begin
          r.sec_tens = d.sec_tens + 4'd1;
        end
      end else begin
        r.sec_ones = d.sec_ones + 4'd1;
      end
    end else begin
      if (d.sec_ones == 4'd0) begin
        r.sec_ones = 4'd9;
        if (d.sec_tens == 4'd0) begin
          r.sec_tens = 4'd5;
          r.min_ones = d.min_ones - 4'd1;
        end else begin
          r.sec_tens = d.sec_tens - 4'd1;
        end
      end else begin
        r.sec_ones = d.sec_ones - 4'd1;
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/round_timer_seg7.sv
// ---------------------------------------------------------------------------
// round_timer_seg7
// BCD to active-low 7-segment decoder; codes above 9 blank the digit.
//   bcd_i [3:0] : BCD digit
//   seg_o [6:0] : segments gfedcba, 0 = lit
// ---------------------------------------------------------------------------
module round_timer_seg7
  import round_timer_pkg::*;
(
  input  logic [3:0] bcd_i,
  output logic [6:0] seg_o
);

  always_comb begin
    // NOTE: default assignment first so every path drives seg_o (no latch).
    seg_o = SEG_BLANK;
    if (bcd_i <= 4'd9) begin
      seg_o = SEG_DIGITS[bcd_i];
    end
  end

endmodule

// File: rtl/round_timer.sv
// ---------------------------------------------------------------------------
// round_timer
// Round timer counting M:SS up to, or down from, a fixed limit.
// Parameters:
//   TICK_DIV  : clock cycles per one-second tick (>= 2)
//   LIMIT_MIN : round-limit minutes digit (0-9)
//   LIMIT_SEC : round-limit seconds (0-59)
// Ports:
//   Clock, Resetn            : clock, asynchronous active-low reset
//   start                    : one-cycle start/restart (latches mode)
//   clear                    : synchronous return to idle (highest priority)
//   pause                    : level, freezes the count while high
//   mode                     : 0 = count up, 1 = count down
//   sec_ones/sec_tens/min_ones: BCD display digits
//   tick                     : one-cycle strobe when a second elapses
//   running                  : high in RUN and PAUSE
//   timeout                  : high while in DONE
//   done_pulse               : one cycle on entry to DONE
//   HEX0/HEX1/HEX2           : active-low segments for the three digits
// Build option: define ROUND_TIMER_SEG_EN to build the segment decoders;
// otherwise the HEX outputs are tied blank.
// ---------------------------------------------------------------------------
module round_timer
  import round_timer_pkg::*;
#(
  parameter int TICK_DIV  = 50000000,
  parameter int LIMIT_MIN = 1,
  parameter int LIMIT_SEC = 0
) (
  input  logic       Clock,
  input  logic       Resetn,
  input  logic       start,
  input  logic       clear,
  input  logic       pause,
  input  logic       mode,
  output logic [3:0] sec_ones,
  output logic [3:0] sec_tens,
  output logic [3:0] min_ones,
  output logic       tick,
  output logic       running,
  output logic       timeout,
  output logic       done_pulse,
  output logic [6:0] HEX0,
  output logic [6:0] HEX1,
  output logic [6:0] HEX2
);

  localparam int             PW        = $clog2(TICK_DIV);
  localparam logic [PW-1:0]  PRESC_MAX = PW'(TICK_DIV - 1);
  localparam digits_t        LIMIT     = digits_t'({4'(LIMIT_MIN), 4'(LIMIT_SEC / 10),
                                                    4'(LIMIT_SEC % 10)});
  localparam digits_t        ZERO      = '0;
  localparam bit             LIMIT_IS_ZERO = (LIMIT_MIN == 0) && (LIMIT_SEC == 0);

  state_e        state_q;
  logic [PW-1:0] presc_q;
  digits_t       digits_q;
  digits_t       digits_d;
  digits_t       target;
  logic          mode_q;
  logic          running_q;
  logic          timeout_q;
  logic          done_pulse_q;
  logic          tick_now;

  assign digits_d = digits_step(digits_q, mode_q);
  assign target   = mode_q ? ZERO : LIMIT;

  // The second elapses only when RUN actually advances this cycle; a clear,
  // restart or pause arriving on the wrap cycle wins and swallows the tick.
  assign tick_now = (state_q == RUN) && (presc_q == PRESC_MAX) && !clear && !start && !pause;

  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      state_q      <= IDLE;
      presc_q      <= '0;
      digits_q     <= ZERO;
      mode_q       <= 1'b0;
      running_q    <= 1'b0;
      timeout_q    <= 1'b0;
      done_pulse_q <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      done_pulse_q <= 1'b0;
      if (clear) begin
        state_q   <= IDLE;
        presc_q   <= '0;
        digits_q  <= ZERO;
        running_q <= 1'b0;
        timeout_q <= 1'b0;
      end else if (start) begin
        mode_q   <= mode;
        presc_q  <= '0;
        digits_q <= mode ? LIMIT : ZERO;
        // A 0:00 limit is already reached at load time in either direction.
        state_q      <= LIMIT_IS_ZERO ? DONE : RUN;
        running_q    <= !LIMIT_IS_ZERO;
        timeout_q    <= LIMIT_IS_ZERO;
        done_pulse_q <= LIMIT_IS_ZERO;
      end else begin
        case (state_q)
          RUN: begin
            if (pause) begin
              state_q <= PAUSE;
            end else if (tick_now) begin
              presc_q  <= '0;
              digits_q <= digits_d;
              if (digits_d == target) begin
                state_q      <= DONE;
                running_q    <= 1'b0;
                timeout_q    <= 1'b1;
                done_pulse_q <= 1'b1;
              end
            end else begin
              presc_q <= presc_q + 1'b1;
            end
          end
          PAUSE: begin
            if (!pause) begin
              state_q <= RUN;
            end
          end
          default: ;
        endcase
      end
    end
  end

  assign sec_ones   = digits_q.sec_ones;
  assign sec_tens   = digits_q.sec_tens;
  assign min_ones   = digits_q.min_ones;
  assign tick       = tick_now;
  assign running    = running_q;
  assign timeout    = timeout_q;
  assign done_pulse = done_pulse_q;

`ifdef ROUND_TIMER_SEG_EN
  round_timer_seg7 u_seg0 (.bcd_i(digits_q.sec_ones), .seg_o(HEX0));
  round_timer_seg7 u_seg1 (.bcd_i(digits_q.sec_tens), .seg_o(HEX1));
  round_timer_seg7 u_seg2 (.bcd_i(digits_q.min_ones), .seg_o(HEX2));
`else
  assign HEX0 = SEG_BLANK;
  assign HEX1 = SEG_BLANK;
  assign HEX2 = SEG_BLANK;
`endif

endmodule
